seven_seg_time_display: RTL



---
 rtl/seven_seg_time_display.sv | 133 +++++++++++++
 1 files changed

// File: rtl/seven_seg_time_display.sv
// seven_seg_time_display
// Snapshots four BCD minute/second digits on each rising edge of the 1 Hz tick
// and time-multiplexes them onto a 4-digit common-anode, active-low 7-segment
// display. The decimal point of the minutes-ones digit acts as a blinking
// colon, and each digit slot begins with an all-anodes-off guard interval.
//
// Ports:
//   clk_100MHz        system clock
//   reset             asynchronous, active-high reset
//   tick_1Hz          50 % duty 1 Hz tick, synchronous to clk_100MHz
//   sec_1s, sec_10s   BCD seconds digits
//   min_1s, min_10s   BCD minutes digits
//   seg[6:0]          cathodes {g,f,e,d,c,b,a}, active-low (registered)
//   dp                decimal point / colon, active-low (registered)
//   an[3:0]           anodes, active-low; an[0]=sec_1s .. an[3]=min_10s (registered)
module seven_seg_time_display #(
  parameter int unsigned REFRESH_DIV  = 100_000,
  parameter int unsigned GUARD_CYCLES = 1_000,
  parameter bit          BLANK_LEAD   = 1'b1
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic       tick_1Hz,
  input  logic [3:0] sec_1s,
  input  logic [3:0] sec_10s,
  input  logic [3:0] min_1s,
  input  logic [3:0] min_10s,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] GUARD_LIM = CNT_W'(GUARD_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic             t1_q, t2_q;
  logic [3:0][3:0]  snap_q, snap_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic [3:0]       an_q, an_d;

  logic       wrap_c;
  logic       load_c;
  logic [3:0] digit_c;

  // BCD to active-low {g..a}; non-decimal codes show a dash
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b0111111;
    endcase
    return s;
  endfunction

  // Next-state and registered-output logic
  always_comb begin
    cnt_d  = cnt_q;
    idx_d  = idx_q;
    snap_d = snap_q;
    seg_d  = 7'h7F;
    dp_d   = 1'b1;
    an_d   = 4'hF;

    wrap_c  = (cnt_q == CNT_MAX);
    // Two-stage tick delay lets the rippling digits settle before capture
    load_c  = t1_q & ~t2_q;
    digit_c = snap_q[idx_q];

    if (wrap_c) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (load_c) begin
      snap_d = {min_10s, min_1s, sec_10s, sec_1s};
    end

    seg_d = bcd_to_seg(digit_c);
    if (BLANK_LEAD && (idx_q == 2'd3) && (snap_q[3] == 4'd0)) begin
      seg_d = 7'h7F;
    end

    // Colon lit during the first half-second while the minutes-ones digit is up
    dp_d = ~((idx_q == 2'd2) & t2_q);

    if (cnt_q >= GUARD_LIM) begin
      an_d = ~(4'b0001 << idx_q);
    end
  end

  // State and output registers
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      idx_q  <= 2'd0;
      t1_q   <= 1'b0;
      t2_q   <= 1'b0;
      snap_q <= '0;
      seg_q  <= 7'h7F;
      dp_q   <= 1'b1;
      an_q   <= 4'hF;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      t1_q   <= tick_1Hz;
      t2_q   <= t1_q;
      snap_q <= snap_d;
      seg_q  <= seg_d;
      dp_q   <= dp_d;
      an_q   <= an_d;
    end
  end

  assign seg = seg_q;
  assign dp  = dp_q;
  assign an  = an_q;

endmodule
